// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if
// Memory-stage port bundle: CPU load/store signals, the priority loader
// write port and store-buffer status flags.
// master = CPU/loader side, slave = the store-buffer responder.
interface dmem_store_buffer_if #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          MemWriteM;
  logic [31:0]   ALUResultM;
  logic [31:0]   WriteDataM;
  logic [31:0]   ReadDataM;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [CW-1:0] sb_count;
  logic          sb_empty;
  logic          sb_overflow;

  modport master (
    output MemWriteM, ALUResultM, WriteDataM, ld_valid, ld_addr, ld_data,
    input  ReadDataM, sb_count, sb_empty, sb_overflow
  );

  modport slave (
    input  MemWriteM, ALUResultM, WriteDataM, ld_valid, ld_addr, ld_data,
    output ReadDataM, sb_count, sb_empty, sb_overflow
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// Data memory with a posted-store FIFO in front of a word-addressed array.
// The array's single write port serves the loader first; buffered CPU
// stores drain one per cycle whenever the loader is idle, so stores never
// stall the pipeline. Loads are answered combinationally.
// Optional feature macro: DMEM_STORE_FWD_EN -- when defined, loads are
// forwarded from the newest matching pending buffer entry.
module dmem_store_buffer #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  dmem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Backing store and FIFO storage (no reset on data).
  logic [31:0]   mem       [2**AW];
  logic [AW-1:0] entryAddr [DEPTH];
  logic [31:0]   entryData [DEPTH];

  logic [PW-1:0] headReg, headNext;
  logic [PW-1:0] tailReg, tailNext;
  logic [CW-1:0] countReg, countNext;
  logic          overflowReg, overflowNext;

  logic          popEn;
  logic          full;
  logic          pushAcc;
  logic          dropStore;
  logic [AW-1:0] storeIdx;
  logic [AW-1:0] readIdx;
  logic [31:0]   arrayData;
  logic [31:0]   readData;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.ALUResultM[31:AW+2], bus.ALUResultM[1:0]};

  assign storeIdx = bus.ALUResultM[AW+1:2];
  assign readIdx  = bus.ALUResultM[AW+1:2];

  // Push/pop decision and next pointer, count and overflow state.
  always_comb begin
    popEn        = (countReg != '0) && !bus.ld_valid;
    full         = (countReg == CW'(DEPTH));
    pushAcc      = bus.MemWriteM && (!full || popEn);
    dropStore    = bus.MemWriteM && full && !popEn;
    headNext     = headReg;
    tailNext     = tailReg;
    countNext    = countReg;
    overflowNext = overflowReg || dropStore;
    if (popEn) begin
      headNext = headReg + PW'(1);
    end
    if (pushAcc) begin
      tailNext = tailReg + PW'(1);
    end
    case ({pushAcc, popEn})
      2'b10:   countNext = countReg + CW'(1);
      2'b01:   countNext = countReg - CW'(1);
      default: countNext = countReg;
    endcase
  end

  // Control state; reset discards all pending stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headReg     <= '0;
      tailReg     <= '0;
      countReg    <= '0;
      overflowReg <= 1'b0;
    end else begin
      headReg     <= headNext;
      tailReg     <= tailNext;
      countReg    <= countNext;
      overflowReg <= overflowNext;
    end
  end

  // Capture an accepted store at the tail slot.
  always_ff @(posedge clk) begin
    if (pushAcc) begin
      entryAddr[tailReg] <= storeIdx;
      entryData[tailReg] <= bus.WriteDataM;
    end
  end

  // Shared array write port: loader has priority, otherwise drain the head.
  always_ff @(posedge clk) begin
    if (bus.ld_valid) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end else if (popEn) begin
      mem[entryAddr[headReg]] <= entryData[headReg];
    end
  end

  assign arrayData = mem[readIdx];

`ifdef DMEM_STORE_FWD_EN
  logic [PW-1:0] fwdSlot [DEPTH];
  logic [DEPTH-1:0] fwdHit;

  // Entry gi counts from the head (oldest) toward the tail (newest).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
      assign fwdSlot[gi] = headReg + PW'(gi);
      assign fwdHit[gi]  = (CW'(gi) < countReg) &&
                           (entryAddr[fwdSlot[gi]] == readIdx);
    end
  endgenerate

  // Oldest-to-newest scan so the newest matching entry wins.
  always_comb begin
    readData = arrayData;
    for (int i = 0; i < DEPTH; i++) begin
      if (fwdHit[i]) begin
        readData = entryData[fwdSlot[i]];
      end
    end
  end
`else
  assign readData = arrayData;
`endif

  assign bus.ReadDataM   = readData;
  assign bus.sb_count    = countReg;
  assign bus.sb_empty    = (countReg == '0);
  assign bus.sb_overflow = overflowReg;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
// Directed checks of the store buffer: reset, store/load latency, aliasing,
// loader backpressure, overflow, loader-vs-store ordering and forwarding.
module tb_dmem_store_buffer;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

`ifdef DMEM_STORE_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  dmem_store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  dmem_store_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end else begin
      $display("check %s got=%h ok", tag, obs);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic lv, input logic [AW-1:0] la, input logic [31:0] ldd);
    bus.MemWriteM  = we;
    bus.ALUResultM = a;
    bus.WriteDataM = d;
    bus.ld_valid   = lv;
    bus.ld_addr    = la;
    bus.ld_data    = ldd;
  endtask

  task automatic readChk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.ALUResultM = a;
    #1;
    checkVal(tag, bus.ReadDataM, exp);
  endtask

  task automatic statChk(input string tag, input int cnt, input logic ovf);
    checkVal({tag, "_cnt"}, 32'(bus.sb_count), 32'(cnt));
    checkVal({tag, "_ovf"}, 32'(bus.sb_overflow), 32'(ovf));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    statChk("rst0", 0, 1'b0);
    checkVal("rst0_empty", 32'(bus.sb_empty), 32'd1);
    cycle();
    cycle();
    reset = 1'b1;

    // Basic store/load with latency and aliasing.
    drive(0, 0, 0, 1, 10'd16, 32'h0);
    cycle();
    drive(1, 32'h40, 32'hDEADBEEF, 0, 0, 0);
    #1 checkVal("same_cycle", bus.ReadDataM, 32'h0);
    cycle();
    statChk("st_push", 1, 1'b0);
    drive(0, 32'h40, 0, 0, 0, 0);
    readChk("st_edge1", 32'h40, Fwd ? 32'hDEADBEEF : 32'h0);
    cycle();
    statChk("st_drain", 0, 1'b0);
    checkVal("st_empty", 32'(bus.sb_empty), 32'd1);
    readChk("ld_40", 32'h40, 32'hDEADBEEF);
    cycle();
    readChk("ld_43", 32'h43, 32'hDEADBEEF);

    // Sustained stores with loader idle: occupancy stays at 1.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h60 + 32'(4 * i), 32'h100 + 32'(i), 0, 0, 0);
      cycle();
      checkVal($sformatf("sus%0d_cnt", i), 32'(bus.sb_count), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    statChk("sus_end", 0, 1'b0);
    readChk("sus_68", 32'h68, 32'h102);

    // Loader backpressure: fill to 4, loader zeroes words 4..7 meanwhile.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1, AW'(4 + i), 32'h0);
      cycle();
      statChk($sformatf("bp_fill%0d", i), i + 1, 1'b0);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkVal($sformatf("bp_drain%0d_cnt", i), 32'(bus.sb_count), 32'(3 - i));
      readChk($sformatf("bp_drain%0d_done", i), 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
      if (i < 3) begin
        readChk($sformatf("bp_drain%0d_next", i), 32'h14 + 32'(4 * i), Fwd ? 32'hA1 + 32'(i) : 32'h0);
      end
    end

    // Overflow: loader holds the port (zeroing word 11), 5 stores.
    for (int i = 0; i < 5; i++) begin
      drive(1, (i < 4) ? 32'h30 + 32'(4 * i) : 32'h2C, 32'hB0 + 32'(i), 1, 10'd11, 32'h0);
      cycle();
      statChk($sformatf("ovf%0d", i), (i < 4) ? i + 1 : 4, (i == 4));
    end
    drive(1, 32'h28, 32'hC5, 0, 0, 0);
    cycle();
    statChk("full_pushpop", 4, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    statChk("ovf_drained", 0, 1'b1);
    readChk("ovf_28", 32'h28, 32'hC5);
    readChk("ovf_2c_dropped", 32'h2C, 32'h0);
    readChk("ovf_30", 32'h30, 32'hB0);
    readChk("ovf_3c", 32'h3C, 32'hB3);

    // Loader write to an address with a pending CPU store.
    drive(1, 32'h20, 32'hAAAA0000, 0, 0, 0);
    cycle();
    checkVal("lvp_push_cnt", 32'(bus.sb_count), 32'd1);
    drive(0, 32'h20, 0, 1, 10'd8, 32'h55550000);
    cycle();
    checkVal("lvp_hold_cnt", 32'(bus.sb_count), 32'd1);
    drive(0, 32'h20, 0, 0, 0, 0);
    readChk("lvp_pending", 32'h20, Fwd ? 32'hAAAA0000 : 32'h55550000);
    cycle();
    checkVal("lvp_drain_cnt", 32'(bus.sb_count), 32'd0);
    readChk("lvp_final", 32'h20, 32'hAAAA0000);

    // Two pending stores to the same word.
    drive(0, 0, 0, 1, 10'd32, 32'h33333333);
    cycle();
    drive(1, 32'h80, 32'h11111111, 1, 10'h3FF, 32'h0);
    cycle();
    drive(1, 32'h80, 32'h22222222, 1, 10'h3FF, 32'h0);
    cycle();
    drive(0, 32'h80, 0, 1, 10'h3FF, 32'h0);
    checkVal("fwd_cnt", 32'(bus.sb_count), 32'd2);
    readChk("fwd_80", 32'h80, Fwd ? 32'h22222222 : 32'h33333333);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    readChk("fwd_final", 32'h80, 32'h22222222);

    // Reset mid-drain: preload words 20..22, queue 3 stores, drain one.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, AW'(20 + i), 32'h77);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h50 + 32'(4 * i), 32'hD0 + 32'(i), 1, 10'h3FF, 32'h0);
      cycle();
    end
    checkVal("mid_cnt", 32'(bus.sb_count), 32'd3);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    checkVal("mid_drain_cnt", 32'(bus.sb_count), 32'd2);
    #1 reset = 1'b0;
    #1;
    statChk("rst_async", 0, 1'b0);
    checkVal("rst_async_empty", 32'(bus.sb_empty), 32'd1);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    checkVal("post_rst_cnt", 32'(bus.sb_count), 32'd0);
    readChk("post_rst_50", 32'h50, 32'hD0);
    readChk("post_rst_54", 32'h54, 32'h77);
    readChk("post_rst_58", 32'h58, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
